// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer_pkg
//  Description : State encodings, default cycle counts and output decode
//                shared by the reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

    localparam logic [2:0] c_st_mmcm_reset = 3'd0;
    localparam logic [2:0] c_st_wait_lock  = 3'd1;
    localparam logic [2:0] c_st_dram_reset = 3'd2;
    localparam logic [2:0] c_st_wait_calib = 3'd3;
    localparam logic [2:0] c_st_release    = 3'd4;
    localparam logic [2:0] c_st_run        = 3'd5;
    localparam logic [2:0] c_st_fault      = 3'd6;

    typedef enum logic [2:0] {
        ST_MMCM_RESET = c_st_mmcm_reset,
        ST_WAIT_LOCK  = c_st_wait_lock,
        ST_DRAM_RESET = c_st_dram_reset,
        ST_WAIT_CALIB = c_st_wait_calib,
        ST_RELEASE    = c_st_release,
        ST_RUN        = c_st_run,
        ST_FAULT      = c_st_fault
    } state_t;

    localparam int c_default_sync_stages   = 2;
    localparam int c_default_mmcm_cycles   = 16;
    localparam int c_default_lock_cycles   = 1024;
    localparam int c_default_dram_cycles   = 256;
    localparam int c_default_calib_timeout = 16777215;
    localparam int c_default_max_retries   = 3;
    localparam int c_default_counter_width = 24;

    typedef struct packed {
        logic mmcm_reset;
        logic dram_sys_reset;
        logic dram_aresetn;
        logic top_reset;
        logic ready;
        logic fault;
    } outs_t;

    localparam outs_t c_reset_outs = '{
        mmcm_reset: 1'b1, dram_sys_reset: 1'b1, dram_aresetn: 1'b0,
        top_reset: 1'b1, ready: 1'b0, fault: 1'b0
    };

    function automatic outs_t decode_outputs(input state_t s);
        outs_t o;
        o = '{mmcm_reset: 1'b0, dram_sys_reset: 1'b0, dram_aresetn: 1'b0,
              top_reset: 1'b1, ready: 1'b0, fault: 1'b0};
        case (s)
            ST_MMCM_RESET: begin
                o.mmcm_reset     = 1'b1;
                o.dram_sys_reset = 1'b1;
            end
            ST_WAIT_LOCK:  o.dram_sys_reset = 1'b1;
            ST_DRAM_RESET: o.dram_sys_reset = 1'b1;
            ST_WAIT_CALIB: o.dram_sys_reset = 1'b0;
            ST_RELEASE:    o.dram_aresetn   = 1'b1;
            ST_RUN: begin
                o.dram_aresetn = 1'b1;
                o.top_reset    = 1'b0;
                o.ready        = 1'b1;
            end
            default: begin
                o       = c_reset_outs;
                o.fault = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : Multi-flop synchroniser for one asynchronous status bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_comb sync_d = i_d;
        end else begin : g_chain
            always_comb sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Staged MMCM / DDR3 / SoC reset bring-up with retry and fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES          = c_default_sync_stages,
    parameter int MMCM_RESET_CYCLES    = c_default_mmcm_cycles,
    parameter int LOCK_STABLE_CYCLES   = c_default_lock_cycles,
    parameter int DRAM_RESET_CYCLES    = c_default_dram_cycles,
    parameter int CALIB_TIMEOUT_CYCLES = c_default_calib_timeout,
    parameter int MAX_RETRIES          = c_default_max_retries,
    parameter int COUNTER_WIDTH        = c_default_counter_width
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_top_locked,
    input  logic       i_uart_locked,
    input  logic       i_ethernet_locked,
    input  logic       i_calib_complete,
    output logic       o_mmcm_reset,
    output logic       o_dram_sys_reset,
    output logic       o_dram_aresetn,
    output logic       o_top_reset,
    output logic       o_ready,
    output logic       o_fault,
    output logic [2:0] o_state,
    output logic [1:0] o_retry_count
);

    localparam logic [COUNTER_WIDTH-1:0] c_mmcm_load  = COUNTER_WIDTH'(MMCM_RESET_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_lock_load  = COUNTER_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_dram_load  = COUNTER_WIDTH'(DRAM_RESET_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_calib_load = COUNTER_WIDTH'(CALIB_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]               c_retry_max  = 2'(MAX_RETRIES);
    localparam logic [1:0]               c_retry_last = 2'(MAX_RETRIES - 1);

    logic w_top_locked;
    logic w_uart_locked;
    logic w_eth_locked;
    logic w_calib;
    logic w_all_locked;
    logic w_fail;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]               retry_q, retry_d;
    outs_t                    outs_q, outs_d;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_top (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_d(i_top_locked), .o_q(w_top_locked)
    );
    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uart (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_d(i_uart_locked), .o_q(w_uart_locked)
    );
    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_eth (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_d(i_ethernet_locked), .o_q(w_eth_locked)
    );
    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_calib (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_d(i_calib_complete), .o_q(w_calib)
    );

    assign w_all_locked = w_top_locked & w_uart_locked & w_eth_locked;

    function automatic logic [COUNTER_WIDTH-1:0] load_for(input state_t s);
        case (s)
            ST_MMCM_RESET: return c_mmcm_load;
            ST_WAIT_LOCK:  return c_lock_load;
            ST_DRAM_RESET: return c_dram_load;
            ST_WAIT_CALIB: return c_calib_load;
            default:       return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        w_fail  = 1'b0;

        case (state_q)
            ST_MMCM_RESET: begin
                if (cnt_q == '0) state_d = ST_WAIT_LOCK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WAIT_LOCK: begin
                if (!w_all_locked)    cnt_d   = c_lock_load;
                else if (cnt_q == '0) state_d = ST_DRAM_RESET;
                else                  cnt_d   = cnt_q - 1'b1;
            end
            ST_DRAM_RESET: begin
                if (!w_all_locked)    w_fail  = 1'b1;
                else if (cnt_q == '0) state_d = ST_WAIT_CALIB;
                else                  cnt_d   = cnt_q - 1'b1;
            end
            ST_WAIT_CALIB: begin
                // calib is tested before expiry so a same-cycle arrival wins
                if (!w_all_locked)    w_fail  = 1'b1;
                else if (w_calib)     state_d = ST_RELEASE;
                else if (cnt_q == '0) w_fail  = 1'b1;
                else                  cnt_d   = cnt_q - 1'b1;
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN: begin
                if (!w_all_locked || !w_calib) w_fail = 1'b1;
            end
            default: state_d = ST_FAULT;
        endcase

        if (w_fail) begin
            if (retry_q == c_retry_last) begin
                state_d = ST_FAULT;
                retry_d = c_retry_max;
            end else begin
                state_d = ST_MMCM_RESET;
                retry_d = retry_q + 2'd1;
            end
        end

        if (state_d != state_q) cnt_d = load_for(state_d);

        outs_d = decode_outputs(state_d);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_MMCM_RESET;
            cnt_q   <= c_mmcm_load;
            retry_q <= '0;
            outs_q  <= c_reset_outs;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            outs_q  <= outs_d;
        end
    end

    assign o_mmcm_reset     = outs_q.mmcm_reset;
    assign o_dram_sys_reset = outs_q.dram_sys_reset;
    assign o_dram_aresetn   = outs_q.dram_aresetn;
    assign o_top_reset      = outs_q.top_reset;
    assign o_ready          = outs_q.ready;
    assign o_fault          = outs_q.fault;
    assign o_state          = state_q;
    assign o_retry_count    = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Scoreboard bench for reset_sequencer with reduced cycle counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst_n;
    logic       top_locked, uart_locked, eth_locked, calib;
    logic       mmcm_reset, dram_sys_reset, dram_aresetn, top_reset, ready, fault;
    logic [2:0] state;
    logic [1:0] retry;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] retry;
        logic       mmcm;
        logic       sys;
        logic       aresetn;
        logic       top;
        logic       ready;
        logic       fault;
    } obs_t;

    typedef struct {
        obs_t o;
        int   dwell;
    } exp_t;

    exp_t exp_q[$];

    reset_sequencer #(
        .SYNC_STAGES(SYNC_STAGES),
        .MMCM_RESET_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .DRAM_RESET_CYCLES(4),
        .CALIB_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(3),
        .COUNTER_WIDTH(24)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_top_locked(top_locked),
        .i_uart_locked(uart_locked),
        .i_ethernet_locked(eth_locked),
        .i_calib_complete(calib),
        .o_mmcm_reset(mmcm_reset),
        .o_dram_sys_reset(dram_sys_reset),
        .o_dram_aresetn(dram_aresetn),
        .o_top_reset(top_reset),
        .o_ready(ready),
        .o_fault(fault),
        .o_state(state),
        .o_retry_count(retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t cur_obs();
        return {state, retry, mmcm_reset, dram_sys_reset, dram_aresetn, top_reset, ready, fault};
    endfunction

    // Hand-written output table per state.
    function automatic obs_t expect_obs(input int st, input int rc);
        obs_t o;
        o = '0;
        o.st    = 3'(st);
        o.retry = 2'(rc);
        o.top   = 1'b1;
        case (st)
            0: begin o.mmcm = 1'b1; o.sys = 1'b1; end
            1: o.sys = 1'b1;
            2: o.sys = 1'b1;
            4: o.aresetn = 1'b1;
            5: begin o.aresetn = 1'b1; o.top = 1'b0; o.ready = 1'b1; end
            6: begin o.mmcm = 1'b1; o.sys = 1'b1; o.fault = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input int st, input int rc, input int dwell);
        exp_t e;
        e.o     = expect_obs(st, rc);
        e.dwell = dwell;
        exp_q.push_back(e);
    endtask

    task automatic check_obs(input string name, input obs_t exp);
        obs_t got;
        got = cur_obs();
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic wait_cond(input string name, input int st, input int rc, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(state == 3'(st) && (rc < 0 || retry == 2'(rc))) && n < budget);
        if (!(state == 3'(st) && (rc < 0 || retry == 2'(rc)))) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout, state %0d retry %0d, required state %0d", name, state, retry, st);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s: %0d expected transitions never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_obs(name, expect_obs(0, 0));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every state change is matched against the next expected entry,
    // including how many cycles the previous state was held.
    initial begin : monitor
        logic [2:0] prev;
        int         dwell;
        exp_t       e;
        obs_t       got;
        prev  = 3'd0;
        dwell = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev  = 3'd0;
                dwell = 0;
            end else begin
                dwell++;
                if (state != prev) begin
                    got = cur_obs();
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_transition: got %h after %0d cycles, required no transition", got, dwell);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e.o || (e.dwell >= 0 && dwell != e.dwell)) begin
                            fails++;
                            $display("FAIL transition_to_%0d: got %h dwell %0d, required %h dwell %0d",
                                     e.o.st, got, dwell, e.o, e.dwell);
                        end
                    end
                    prev  = state;
                    dwell = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        rst_n       = 1'b0;
        top_locked  = 1'b1;
        uart_locked = 1'b1;
        eth_locked  = 1'b1;
        calib       = 1'b0;
        repeat (2) @(negedge clk);
        check_obs("por_reset_values", expect_obs(0, 0));

        // Nominal bring-up: calib arrives 10 cycles into WAIT_CALIB.
        push(1, 0, 4); push(2, 0, 8); push(3, 0, 4); push(4, 0, 13); push(5, 0, 1);
        @(negedge clk) rst_n = 1'b1;
        wait_cond("nominal_wait_calib", 3, -1, 100);
        repeat (10) @(negedge clk);
        calib = 1'b1;
        wait_cond("nominal_run", 5, -1, 100);
        drain("nominal");
        do_reset("reset_after_run");

        // One-cycle lock glitch at count 5 of WAIT_LOCK restarts the window.
        calib = 1'b0;
        push(1, 0, 4); push(2, 0, 16);
        @(negedge clk) rst_n = 1'b1;
        wait_cond("glitch_wait_lock", 1, -1, 100);
        repeat (5) @(negedge clk);
        uart_locked = 1'b0;
        @(negedge clk) uart_locked = 1'b1;
        wait_cond("glitch_dram_reset", 2, -1, 100);
        drain("glitch");
        do_reset("reset_after_glitch");

        // Calibration never completes: three timeouts then sticky fault.
        push(1, 0, 4); push(2, 0, 8); push(3, 0, 4); push(0, 1, 32);
        push(1, 1, 4); push(2, 1, 8); push(3, 1, 4); push(0, 2, 32);
        push(1, 2, 4); push(2, 2, 8); push(3, 2, 4); push(6, 3, 32);
        @(negedge clk) rst_n = 1'b1;
        wait_cond("timeout_fault", 6, -1, 500);
        drain("timeout");
        repeat (20) @(negedge clk);
        check_obs("fault_hold", expect_obs(6, 3));
        do_reset("reset_from_fault");

        // Lock loss in RUN, then recovery with retry held at 1.
        push(1, 0, 4); push(2, 0, 8); push(3, 0, 4); push(4, 0, 13); push(5, 0, 1);
        @(negedge clk) rst_n = 1'b1;
        wait_cond("runloss_wait_calib", 3, -1, 100);
        repeat (10) @(negedge clk);
        calib = 1'b1;
        wait_cond("runloss_run", 5, -1, 100);
        drain("runloss_bringup");
        push(0, 1, -1); push(1, 1, 4); push(2, 1, 8); push(3, 1, 4); push(4, 1, 1); push(5, 1, 1);
        @(negedge clk) eth_locked = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state != 3'd0 && n < 10);
        checks++;
        if (n > SYNC_STAGES + 1) begin
            fails++;
            $display("FAIL runloss_latency: got %0d cycles, required at most %0d", n, SYNC_STAGES + 1);
        end
        eth_locked = 1'b1;
        wait_cond("runloss_recover", 5, 1, 100);
        drain("runloss_recover");

        // Calib drop in RUN, then async reset in the middle of WAIT_CALIB.
        push(0, 2, -1); push(1, 2, 4); push(2, 2, 8); push(3, 2, 4);
        @(negedge clk) calib = 1'b0;
        wait_cond("midcalib_wait", 3, 2, 100);
        repeat (5) @(negedge clk);
        drain("midcalib");
        do_reset("async_reset_mid_calib");

        // One timeout, then calib lands exactly on the expiry cycle.
        push(1, 0, 4); push(2, 0, 8); push(3, 0, 4); push(0, 1, 32);
        push(1, 1, 4); push(2, 1, 8); push(3, 1, 4); push(4, 1, 32); push(5, 1, 1);
        @(negedge clk) rst_n = 1'b1;
        wait_cond("edge_second_calib", 3, 1, 300);
        repeat (29) @(negedge clk);
        calib = 1'b1;
        wait_cond("edge_run", 5, 1, 100);
        drain("edge");
        check_obs("edge_run_outputs", expect_obs(5, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Board-level reset and bring-up sequencer that sits directly upstream of the SoC top and the DDR3 memory controller in the synthesis wrapper. It consumes the three MMCM LOCKED flags and the controller's init_calib_complete, and produces staged resets in a fixed order: MMCM reset, DRAM sys_rst, DRAM aresetn, then SoC reset. It retries bring-up on lock loss or calibration timeout, and latches a fault after a bounded number of retries. It runs on the raw 100 MHz board clock, so it operates while the MMCMs are unlocked.

Parameters:
SYNC_STAGES, 2, flop stages on each asynchronous status input
MMCM_RESET_CYCLES, 16, cycles o_mmcm_reset is held per attempt
LOCK_STABLE_CYCLES, 1024, consecutive cycles all locks must be high
DRAM_RESET_CYCLES, 256, cycles o_dram_sys_reset is held after locks are stable
CALIB_TIMEOUT_CYCLES, 16777215, maximum cycles to wait for calibration
MAX_RETRIES, 3, failed attempts tolerated before fault
COUNTER_WIDTH, 24, width of the shared down-counter; every *_CYCLES value is at most 2^COUNTER_WIDTH

Ports:
i_clock  input  1  raw board clock, 100 MHz
i_reset_n  input  1  asynchronous active-low reset
i_top_locked  input  1  top/DRAM MMCM LOCKED, asynchronous
i_uart_locked  input  1  UART MMCM LOCKED, asynchronous
i_ethernet_locked  input  1  Ethernet MMCM LOCKED, asynchronous
i_calib_complete  input  1  DDR3 init_calib_complete, asynchronous
o_mmcm_reset  output  1  RST to all MMCMs, active high
o_dram_sys_reset  output  1  controller sys_rst, active high
o_dram_aresetn  output  1  controller AXI aresetn, active low
o_top_reset  output  1  SoC reset, active high
o_ready  output  1  system running
o_fault  output  1  retries exhausted; sticky
o_state  output  3  current state encoding
o_retry_count  output  2  failed attempts so far, saturating

Behaviour:
- Reset (i_reset_n low, async): state=MMCM_RESET, counter=MMCM_RESET_CYCLES-1, retry=0, o_mmcm_reset=1, o_dram_sys_reset=1, o_dram_aresetn=0, o_top_reset=1, o_ready=0, o_fault=0, sync flops=0.
- All four status inputs pass through SYNC_STAGES flops before use. All latencies below count from the synchronised value.
- All outputs are registered and decoded from next_state, so they change on the same edge as o_state.
- Shared down-counter: loaded with N-1 on state entry; the state exits on the cycle the counter reads 0, giving exactly N cycles of dwell.
- States and encodings:
  - MMCM_RESET (0): mmcm_reset=1. Exits to WAIT_LOCK after MMCM_RESET_CYCLES.
  - WAIT_LOCK (1): mmcm_reset=0. Requires all three locks high. Any lock low reloads the counter. Exits to DRAM_RESET after LOCK_STABLE_CYCLES of consecutive all-high.
  - DRAM_RESET (2): dram_sys_reset=1. Exits to WAIT_CALIB after DRAM_RESET_CYCLES.
  - WAIT_CALIB (3): dram_sys_reset=0, aresetn=0. Exits to RELEASE when calib is high. If the counter expires first, this is a failure.
  - RELEASE (4): aresetn=1, top_reset=1, held for 1 cycle. Exits to RUN.
  - RUN (5): top_reset=0, ready=1. Any lock low or calib low is a failure.
  - FAULT (6): outputs match reset values except fault=1 and mmcm_reset=1. Terminal until i_reset_n.
- Failure handling:
  - If retry == MAX_RETRIES-1, go to FAULT and set retry=MAX_RETRIES.
  - Otherwise increment retry and go to MMCM_RESET.
  - Lock loss in DRAM_RESET or WAIT_CALIB is also a failure.
- Simultaneous events:
  - In WAIT_CALIB, calib rising on the same cycle the counter reaches 0 counts as success.
  - In RUN, lock loss and calib drop together count as a single failure.
- o_retry_count is never cleared except by i_reset_n. A successful RUN keeps the count.

Decomposition:
- Shared package/include reset_sequencer_pkg holds:
  - state encodings (3-bit localparams 0-6);
  - default cycle constants.
- Sub-module sync_bit: parameterised SYNC_STAGES synchroniser with asynchronous active-low reset to 0, ASYNC_REG attribute on its flops. Instantiated four times.

Test Plan:
- Defaults overridden to MMCM 4 / LOCK 8 / DRAM 4 / TIMEOUT 32 / RETRIES 3. Release reset, locks high from cycle 0, calib high 10 cycles after aresetn is driven low -> state sequence 0,1,2,3,4,5. mmcm_reset high for exactly 4 cycles. o_ready=1 and o_top_reset=0 on the cycle after RELEASE.
- Same setup, one lock glitches low for 1 cycle at count 5 of WAIT_LOCK -> counter restarts. DRAM_RESET is entered 8 cycles after the glitch clears; retry stays 0.
- Calib never asserts -> three timeouts of 32 cycles each, with retry going 1, 2, then 3. Then o_fault=1, o_state=6, o_mmcm_reset=1 held until i_reset_n.
- In RUN, drop i_ethernet_locked -> o_ready=0, o_top_reset=1, o_state=0 within SYNC_STAGES+1 cycles; retry=1. Restoring the lock returns to RUN with retry still 1.
- Assert i_reset_n low mid-WAIT_CALIB -> all outputs reach reset values asynchronously; retry=0.
- Calib rises on the exact timeout cycle -> RELEASE is entered; retry is unchanged.
